// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one RAMControl port among N requesters.
// Each grant runs latch -> ramReady low -> ramReady high -> ack, with an optional ownership lock.
module ram_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 255,
    parameter int TW      = 8,
    localparam int OW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    lock,
    input  logic [N-1:0]    cmd,
    input  logic [23*N-1:0] addr,
    input  logic [16*N-1:0] wdata,
    output logic [N-1:0]    ack,
    output logic [N-1:0]    err,
    output logic [15:0]     rdata,
    output logic [OW-1:0]   owner,
    output logic            busy,
    output logic            ramInstruction,
    output logic            ramLatch,
    output logic [22:0]     ramBusAddr,
    output logic [15:0]     ramBusDataIn,
    input  logic [15:0]     ramBusDataOut,
    input  logic            ramReady
);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_LOW, S_WAIT_HIGH, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [OW-1:0] ptr_q, ptr_d, owner_q, owner_d;
    logic [TW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          err_q, err_d, instr_q, instr_d;
    logic [15:0]   rdata_q, rdata_d, wdata_q, wdata_d;
    logic [22:0]   addr_q, addr_d;

    logic          grant_vld, g_instr, tmo;
    logic [OW-1:0] grant_idx, owner_nxt;
    logic [OW:0]   sum;
    logic [22:0]   g_addr;
    logic [15:0]   g_wdata;

    // Scan from the pointer downwards in reverse so the closest set request wins last.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        sum       = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, ptr_q} + (OW+1)'(k);
            if (sum >= (OW+1)'(N)) sum = sum - (OW+1)'(N);
            if (req[sum[OW-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = sum[OW-1:0];
            end
        end
    end

    always_comb begin
        g_instr = 1'b0;
        g_addr  = '0;
        g_wdata = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_idx == OW'(i)) begin
                g_instr = cmd[i];
                g_addr  = addr[23*i +: 23];
                g_wdata = wdata[16*i +: 16];
            end
        end
    end

    // Counter saturates at TIMEOUT; tmo fires on the TIMEOUT-th cycle in a wait state.
    assign cnt_inc   = (cnt_q == TW'(TIMEOUT)) ? cnt_q : cnt_q + 1'b1;
    assign tmo       = (cnt_inc == TW'(TIMEOUT));
    assign owner_nxt = (owner_q == OW'(N - 1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        instr_d = instr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (grant_vld && ramReady) begin
                    owner_d = grant_idx;
                    instr_d = g_instr;
                    addr_d  = g_addr;
                    wdata_d = g_wdata;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                err_d   = 1'b0;
                state_d = S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
                cnt_d = cnt_inc;
                if (!ramReady) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_HIGH;
                end else if (tmo) begin
                    state_d = S_DONE;
                end
            end
            S_WAIT_HIGH: begin
                cnt_d = cnt_inc;
                if (ramReady) begin
                    if (!instr_q) rdata_d = ramBusDataOut;
                    state_d = S_DONE;
                end else if (tmo) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                ptr_d   = (lock[owner_q] && req[owner_q]) ? owner_q : owner_nxt;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            instr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            instr_q <= instr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        ack = '0;
        err = '0;
        if (state_q == S_DONE) begin
            ack[owner_q] = 1'b1;
            err[owner_q] = err_q;
        end
    end

    assign busy           = (state_q != S_IDLE);
    assign ramLatch       = (state_q == S_ISSUE);
    assign rdata          = rdata_q;
    assign owner          = owner_q;
    assign ramInstruction = instr_q;
    assign ramBusAddr     = addr_q;
    assign ramBusDataIn   = wdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter (N=4, TIMEOUT=8) with a simple RAMControl ready model.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, lock, cmd, ack, err;
    logic [91:0] addr;
    logic [63:0] wdata;
    logic [15:0] rdata, ramBusDataIn, ramBusDataOut;
    logic [1:0]  owner;
    logic        busy, ramInstruction, ramLatch, ramReady;
    logic [22:0] ramBusAddr;

    int n_checks = 0, n_fail = 0;

    // RAM model controls: mode 0 never drops ready, 1 drops for low_len cycles, 2 drops until rel
    int          mode = 1, low_len = 3;
    logic        rel = 1'b0;
    logic [15:0] model_rdata = 16'h0;

    int          latch_cnt = 0, ack_cnt = 0;
    logic [22:0] last_addr;
    logic [15:0] last_wd;
    logic        last_instr;

    ram_arbiter #(.N(4), .TIMEOUT(8), .TW(8)) dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock), .cmd(cmd), .addr(addr), .wdata(wdata),
        .ack(ack), .err(err), .rdata(rdata), .owner(owner), .busy(busy),
        .ramInstruction(ramInstruction), .ramLatch(ramLatch), .ramBusAddr(ramBusAddr),
        .ramBusDataIn(ramBusDataIn), .ramBusDataOut(ramBusDataOut), .ramReady(ramReady)
    );

    always #5 clk = ~clk;

    initial begin
        ramReady = 1'b1;
        ramBusDataOut = 16'h0;
        forever begin
            @(negedge clk);
            if (ramLatch && mode != 0) begin
                @(posedge clk); #1 ramReady = 1'b0;
                if (mode == 1) repeat (low_len) @(posedge clk);
                else while (!rel) @(posedge clk);
                #1;
                ramBusDataOut = model_rdata;
                ramReady = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (ramLatch) begin
            latch_cnt++;
            last_addr  = ramBusAddr;
            last_wd    = ramBusDataIn;
            last_instr = ramInstruction;
        end
        if (ack != 4'b0) ack_cnt++;
    end

    task automatic wait_ack(input int maxc, output logic [3:0] a, output logic [3:0] e,
                            output int cyc, output logic [15:0] rd, output logic [1:0] ow);
        a = 4'b0; e = 4'b0; cyc = 0; rd = 16'h0; ow = 2'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            cyc = i + 1;
            if (ack != 4'b0) begin
                a = ack; e = err; rd = rdata; ow = owner;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({ack, err} !== 8'h0) begin n_fail++; $display("FAIL reset_ack_err got %h want 00", {ack, err}); end
        n_checks++;
        if ({rdata, owner, busy, ramLatch} !== 20'h0) begin
            n_fail++; $display("FAIL reset_status got rdata=%h owner=%0d busy=%b latch=%b want all 0", rdata, owner, busy, ramLatch);
        end
        n_checks++;
        if ({ramInstruction, ramBusAddr, ramBusDataIn} !== 40'h0) begin
            n_fail++; $display("FAIL reset_bus got instr=%b addr=%h data=%h want all 0", ramInstruction, ramBusAddr, ramBusDataIn);
        end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_single_write();
        logic [3:0] a, e; int cyc, lc0, ac0; logic [15:0] rd; logic [1:0] ow;
        @(posedge clk); #1;
        mode = 1; low_len = 3; lc0 = latch_cnt; ac0 = ack_cnt;
        cmd = 4'b0001; addr[22:0] = 23'h10; wdata[15:0] = 16'hBEEF; req = 4'b0001;
        wait_ack(40, a, e, cyc, rd, ow);
        req = 4'b0;
        n_checks++; if (a !== 4'b0001) begin n_fail++; $display("FAIL wr_ack got %b want 0001", a); end
        n_checks++; if (e !== 4'b0000) begin n_fail++; $display("FAIL wr_err got %b want 0000", e); end
        n_checks++; if (cyc !== 7) begin n_fail++; $display("FAIL wr_latency got %0d want 7", cyc); end
        n_checks++; if (latch_cnt - lc0 !== 1) begin n_fail++; $display("FAIL wr_latch_count got %0d want 1", latch_cnt - lc0); end
        n_checks++; if (last_addr !== 23'h10) begin n_fail++; $display("FAIL wr_addr got %h want 000010", last_addr); end
        n_checks++; if (last_wd !== 16'hBEEF) begin n_fail++; $display("FAIL wr_data got %h want beef", last_wd); end
        n_checks++; if (last_instr !== 1'b1) begin n_fail++; $display("FAIL wr_instr got %b want 1", last_instr); end
        repeat (10) @(negedge clk);
        n_checks++; if (ack_cnt - ac0 !== 1) begin n_fail++; $display("FAIL wr_ack_once got %0d want 1", ack_cnt - ac0); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_idle_after got busy=%b want 0", busy); end
    endtask

    task automatic test_read_back();
        logic [3:0] a, e; int cyc; logic [15:0] rd; logic [1:0] ow;
        @(posedge clk); #1;
        model_rdata = 16'hBEEF; cmd = 4'b0000; addr[68:46] = 23'h10; req = 4'b0100;
        wait_ack(40, a, e, cyc, rd, ow);
        req = 4'b0; model_rdata = 16'h1234;
        n_checks++; if (a !== 4'b0100) begin n_fail++; $display("FAIL rd_ack got %b want 0100", a); end
        n_checks++; if (rd !== 16'hBEEF) begin n_fail++; $display("FAIL rd_data got %h want beef", rd); end
        n_checks++; if (ow !== 2'd2) begin n_fail++; $display("FAIL rd_owner got %0d want 2", ow); end
        n_checks++; if (last_instr !== 1'b0) begin n_fail++; $display("FAIL rd_instr got %b want 0", last_instr); end
        repeat (5) @(negedge clk);
        n_checks++; if (rdata !== 16'hBEEF) begin n_fail++; $display("FAIL rd_hold got %h want beef", rdata); end
        n_checks++; if (owner !== 2'd2) begin n_fail++; $display("FAIL rd_owner_hold got %0d want 2", owner); end
    endtask

    task automatic test_contention();
        logic [3:0] a, e, exp_a; int cyc; logic [15:0] rd; logic [1:0] ow;
        pulse_reset();
        mode = 1; low_len = 3; cmd = 4'b0000; lock = 4'b0; req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            exp_a = 4'b0001 << (k % 4);
            wait_ack(40, a, e, cyc, rd, ow);
            n_checks++;
            if (a !== exp_a || e !== 4'b0) begin
                n_fail++; $display("FAIL rr_order[%0d] got ack=%b err=%b want ack=%b err=0000", k, a, e, exp_a);
            end
        end
        req = 4'b0;
    endtask

    task automatic test_lock();
        logic [3:0] a, e; int cyc; logic [15:0] rd; logic [1:0] ow;
        pulse_reset();
        cmd = 4'b0001; wdata[15:0] = 16'h1111; req = 4'b0001;
        wait_ack(40, a, e, cyc, rd, ow);
        req = 4'b0;
        n_checks++; if (a !== 4'b0001) begin n_fail++; $display("FAIL lock_setup got %b want 0001", a); end
        lock = 4'b0010; req = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            addr[45:23] = 23'h100 + 23'(k);
            model_rdata = 16'hA000 + 16'(k);
            if (k == 3) lock = 4'b0;
            wait_ack(40, a, e, cyc, rd, ow);
            n_checks++;
            if (a !== 4'b0010 || rd !== 16'hA000 + 16'(k) || last_addr !== 23'h100 + 23'(k)) begin
                n_fail++; $display("FAIL lock_burst[%0d] got ack=%b rdata=%h addr=%h want 0010 %h %h",
                                   k, a, rd, last_addr, 16'hA000 + 16'(k), 23'h100 + 23'(k));
            end
        end
        model_rdata = 16'h5555;
        wait_ack(40, a, e, cyc, rd, ow);
        req = 4'b0;
        n_checks++; if (a !== 4'b0001) begin n_fail++; $display("FAIL lock_release got %b want 0001", a); end
        n_checks++; if (rd !== 16'hA003) begin n_fail++; $display("FAIL write_keeps_rdata got %h want a003", rd); end
    endtask

    task automatic test_timeout();
        logic [3:0] a, e; int cyc; logic [15:0] rd; logic [1:0] ow;
        @(posedge clk); #1;
        mode = 2; rel = 1'b0; cmd = 4'b0000; addr[68:46] = 23'h20; model_rdata = 16'h7777; req = 4'b0100;
        wait_ack(60, a, e, cyc, rd, ow);
        req = 4'b0;
        n_checks++; if (a !== 4'b0100) begin n_fail++; $display("FAIL tmo_high_ack got %b want 0100", a); end
        n_checks++; if (e !== 4'b0100) begin n_fail++; $display("FAIL tmo_high_err got %b want 0100", e); end
        n_checks++; if (cyc !== 12) begin n_fail++; $display("FAIL tmo_high_latency got %0d want 12", cyc); end
        n_checks++; if (rd !== 16'hA003) begin n_fail++; $display("FAIL tmo_high_rdata got %h want a003", rd); end
        rel = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ramReady) break;
        end
        n_checks++; if (ramReady !== 1'b1) begin n_fail++; $display("FAIL tmo_model_release got %b want 1", ramReady); end
        rel = 1'b0;
        @(posedge clk); #1;
        mode = 0; cmd = 4'b1000; addr[91:69] = 23'h30; wdata[63:48] = 16'h0F0F; req = 4'b1000;
        wait_ack(60, a, e, cyc, rd, ow);
        req = 4'b0;
        n_checks++; if (a !== 4'b1000) begin n_fail++; $display("FAIL tmo_low_ack got %b want 1000", a); end
        n_checks++; if (e !== 4'b0000) begin n_fail++; $display("FAIL tmo_low_err got %b want 0000", e); end
        n_checks++; if (cyc !== 11) begin n_fail++; $display("FAIL tmo_low_latency got %0d want 11", cyc); end
        n_checks++; if (last_wd !== 16'h0F0F) begin n_fail++; $display("FAIL tmo_low_wdata got %h want 0f0f", last_wd); end
    endtask

    task automatic test_reset_mid();
        logic [3:0] a, e; int cyc, lc0; logic [15:0] rd; logic [1:0] ow;
        @(posedge clk); #1;
        mode = 2; rel = 1'b0; cmd = 4'b0000; addr[68:46] = 23'h44; req = 4'b0100;
        repeat (4) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || owner !== 2'd2) begin
            n_fail++; $display("FAIL mid_pre got busy=%b owner=%0d want 1 2", busy, owner);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({ack, err, busy, ramLatch, owner, rdata} !== 28'h0) begin
            n_fail++; $display("FAIL mid_rst_status got ack=%b err=%b busy=%b latch=%b owner=%0d rdata=%h want all 0",
                               ack, err, busy, ramLatch, owner, rdata);
        end
        n_checks++;
        if ({ramInstruction, ramBusAddr, ramBusDataIn} !== 40'h0) begin
            n_fail++; $display("FAIL mid_rst_bus got instr=%b addr=%h data=%h want all 0", ramInstruction, ramBusAddr, ramBusDataIn);
        end
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b0;
        lc0 = latch_cnt;
        repeat (6) @(negedge clk);
        n_checks++;
        if (latch_cnt !== lc0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL mid_wait_ready got latches=%0d busy=%b want 0 0", latch_cnt - lc0, busy);
        end
        @(posedge clk); #1;
        mode = 1; low_len = 2; model_rdata = 16'h9999; rel = 1'b1;
        wait_ack(40, a, e, cyc, rd, ow);
        req = 4'b0; rel = 1'b0;
        n_checks++;
        if (a !== 4'b0100 || e !== 4'b0 || rd !== 16'h9999) begin
            n_fail++; $display("FAIL mid_after got ack=%b err=%b rdata=%h want 0100 0000 9999", a, e, rd);
        end
        n_checks++; if (latch_cnt - lc0 !== 1) begin n_fail++; $display("FAIL mid_latch_count got %0d want 1", latch_cnt - lc0); end
    endtask

    initial begin
        rst = 1'b1; req = 4'b0; lock = 4'b0; cmd = 4'b0; addr = '0; wdata = '0;
        test_reset();
        test_single_write();
        test_read_back();
        test_contention();
        test_lock();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single RAMControl port between up to N requesters: DNAInitializer, BubbleSort, DNACrosser and Network.
- Runs round-robin arbitration per transaction, with an optional lock that lets a requester keep the port for bursts.
- Sequences the RAMControl handshake: one-cycle latch pulse, then waits for ramReady to fall and rise again.
- Returns read data and a one-cycle ack to the owning requester.

Parameters:
- N, 4: number of requesters. Index 0 has the highest priority after reset.
- TIMEOUT, 255: maximum cycles spent in either wait state before the transaction is forced complete with an error.
- TW, 8: width of the timeout counter. Must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- req  in  N  per-requester request; held high until ack
- lock  in  N  per-requester keep-ownership hint, sampled at completion
- cmd  in  N  per-requester instruction: READ=0, WRITE=1
- addr  in  23*N  per-requester word address [23:1]; requester i occupies bits [23i+22:23i]
- wdata  in  16*N  per-requester write data; requester i occupies bits [16i+15:16i]
- ack  out  N  one-cycle completion pulse to the owner
- err  out  N  one-cycle pulse alongside ack when the transaction timed out
- rdata  out  16  read data, valid in the ack cycle; held until the next read completes
- owner  out  log2(N) (min 1)  index of the current or last grantee
- busy  out  1  high in any state other than IDLE
- ramInstruction  out  1  to RAMControl
- ramLatch  out  1  to RAMControl; one-cycle pulse
- ramBusAddr  out  23  to RAMControl
- ramBusDataIn  out  16  to RAMControl; write data
- ramBusDataOut  in  16  from RAMControl; read data
- ramReady  in  1  from RAMControl

Behaviour:
- Reset values: ack=0, err=0, rdata=0, owner=0, busy=0, ramLatch=0, ramInstruction=0, ramBusAddr=0, ramBusDataIn=0. State=IDLE, RR pointer=0, timeout counter=0.
- IDLE:
  - If any req bit is high and ramReady=1, pick the first set req scanning from pointer, pointer+1, ... modulo N.
  - Register owner and load ramInstruction/ramBusAddr/ramBusDataIn from the winner's slices. Go to ISSUE.
  - If ramReady=0, no grant is made and the state stays IDLE.
- ISSUE:
  - Assert ramLatch for exactly this one cycle; addr/data/instruction are stable in this cycle and stay stable until completion.
  - Clear the timeout counter. Go to WAIT_LOW.
- WAIT_LOW:
  - Wait for ramReady=0, then go to WAIT_HIGH with the counter cleared.
  - If the counter reaches TIMEOUT with ramReady still 1, treat the transaction as completed without a visible busy phase. Go to DONE with no error.
- WAIT_HIGH:
  - Wait for ramReady=1, then go to DONE.
  - If the counter reaches TIMEOUT first, go to DONE with err flagged.
- DONE (one cycle):
  - ack[owner]=1. err[owner]=1 if flagged.
  - If cmd was READ, rdata <= ramBusDataOut sampled at the ramReady rising cycle; on a WRITE, rdata is unchanged.
  - If lock[owner]=1 and req[owner] is still high in this cycle, pointer <= owner (owner keeps priority). Otherwise pointer <= owner+1 mod N.
  - Return to IDLE. Latency from grant to ack is at least 4 cycles.
- Requesters must drop req, or present a new command, in the cycle after ack. A req still high in the cycle after ack is treated as a new request.
- A req dropped before ack is ignored: the transaction still completes and ack is still pulsed.
- Simultaneous requests are resolved by round-robin only. Under continuous contention with lock=0, a requester waits no more than N-1 transactions.
- rst mid-transaction: all state and outputs return immediately to reset values and ramLatch deasserts. RAMControl may still finish the aborted access; the first post-reset grant waits for ramReady=1.
- Widths: the pointer increments modulo N (non-power-of-two N supported). The timeout counter saturates and does not wrap.

Test Plan:
- Single write: req=0001, cmd[0]=1, addr0=0x000010, wdata0=0xBEEF; RAM model drops ready for 3 cycles -> ramLatch pulses once with ramBusAddr=0x000010 and ramBusDataIn=0xBEEF; ack=0001 exactly once, err=0.
- Read back: req[2] reads 0x000010 while the model returns 0xBEEF -> rdata=0xBEEF in the ack[2] cycle; owner=2; rdata holds after ack.
- Contention: req=1111 held, lock=0, each requester re-requests after ack -> grant order 0,1,2,3,0,1...; no requester is skipped.
- Lock burst: req=0011, lock[1]=1 with 4 back-to-back reads from requester 1 -> 4 consecutive acks on requester 1 before requester 0 is served. Drop lock -> the next grant goes to requester 0.
- Timeouts, with TIMEOUT=8:
  - Model drops ready and never raises it -> ack and err on the owner 8 cycles after entering WAIT_HIGH.
  - Model never drops ready -> ack with err=0.
- Reset mid-WAIT_HIGH: assert rst -> all outputs 0 on the same edge. After release with ramReady=0 and req pending -> no ramLatch until ramReady=1.
